// File: rtl/pipe_isa_pkg.sv
// Opcode constants, shadow-slot layout and opcode property decode shared by
// the decoder and the hazard controller.
package pipe_isa_pkg;

    localparam int OP_W  = 4;
    localparam int REG_W = 4;

    localparam logic [OP_W-1:0] OP_ALUR  = 4'b1100;
    localparam logic [OP_W-1:0] OP_ALUI  = 4'b0100;
    localparam logic [OP_W-1:0] OP_CMPR  = 4'b1101;
    localparam logic [OP_W-1:0] OP_CMPI  = 4'b0101;
    localparam logic [OP_W-1:0] OP_LW    = 4'b0111;
    localparam logic [OP_W-1:0] OP_SW    = 4'b0011;
    localparam logic [OP_W-1:0] OP_BCOND = 4'b0010;
    localparam logic [OP_W-1:0] OP_JAL   = 4'b0110;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXM = 2'b01;
    localparam logic [1:0] FWD_MWB = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             wr_en;
        logic             is_load;
        logic             is_mem;
    } slot_t;

    function automatic logic writes_rd(input logic [OP_W-1:0] op);
        case (op)
            OP_ALUR, OP_ALUI, OP_CMPR, OP_CMPI, OP_LW, OP_JAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs1(input logic [OP_W-1:0] op);
        case (op)
            OP_ALUR, OP_ALUI, OP_CMPR, OP_CMPI,
            OP_LW, OP_SW, OP_BCOND, OP_JAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [OP_W-1:0] op);
        case (op)
            OP_ALUR, OP_CMPR, OP_SW, OP_BCOND: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return op == OP_LW;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Compares the ID source registers against the EX and MEM shadow slots.
// Purely combinational: load-use flag and next-cycle forward selects.
module hazard_fwd_sel
    import pipe_isa_pkg::*;
(
    input  logic             id_valid_i,
    input  logic [OP_W-1:0]  id_op_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             ex_vld_i,
    input  logic             ex_wr_i,
    input  logic             ex_ld_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             mem_vld_i,
    input  logic             mem_wr_i,
    input  logic [REG_W-1:0] mem_rd_i,
    output logic             load_use_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o
);

    logic use_a;
    logic use_b;

    assign use_a = id_valid_i & reads_rs1(id_op_i);
    assign use_b = id_valid_i & reads_rs2(id_op_i);

    // Nearest producer wins: EX/MEM result shadows an older MEM/WB one.
    function automatic logic [1:0] pick(input logic used, input logic [REG_W-1:0] r);
        if (!used)                                  return FWD_RF;
        if (ex_vld_i && ex_wr_i && ex_rd_i == r)    return FWD_EXM;
        if (mem_vld_i && mem_wr_i && mem_rd_i == r) return FWD_MWB;
        return FWD_RF;
    endfunction

    assign fwd_a_o = pick(use_a, id_rs1_i);
    assign fwd_b_o = pick(use_b, id_rs2_i);

    assign load_use_o = ex_vld_i & ex_ld_i &
                        ((use_a & (ex_rd_i == id_rs1_i)) |
                         (use_b & (ex_rd_i == id_rs2_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: stall/bubble/flush/freeze are combinational from shadow
// state; forward selects register with 1 clk latency; freeze > redirect > load-use.
module pipeline_hazard_ctrl
    import pipe_isa_pkg::*;
#(
    parameter int REGNO_SEL = 4,
    parameter int OP_FN_SIZ = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [OP_FN_SIZ-1:0] id_op,
    input  logic [REGNO_SEL-1:0] id_rd,
    input  logic [REGNO_SEL-1:0] id_rs1,
    input  logic [REGNO_SEL-1:0] id_rs2,
    input  logic                 ex_redirect,
    input  logic                 mem_ready,
    output logic                 pc_stall,
    output logic                 id_stall,
    output logic                 ex_bubble,
    output logic                 flush,
    output logic                 pipe_freeze,
    output logic                 mem_req,
    output logic [1:0]           ex_fwd_a,
    output logic [1:0]           ex_fwd_b,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    typedef enum logic {RUN, MWAIT} state_e;

    state_e           state_q;
    slot_t            ex_q, mem_q, wb_q, id_slot;
    logic [1:0]       fwd_a_q, fwd_b_q, fwd_a_nxt, fwd_b_nxt;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             frozen, redir_acc, lu_hit, load_use, enter_vld;

    hazard_fwd_sel u_sel (
        .id_valid_i (id_valid),
        .id_op_i    (id_op),
        .id_rs1_i   (id_rs1),
        .id_rs2_i   (id_rs2),
        .ex_vld_i   (ex_q.valid),
        .ex_wr_i    (ex_q.wr_en),
        .ex_ld_i    (ex_q.is_load),
        .ex_rd_i    (ex_q.rd),
        .mem_vld_i  (mem_q.valid),
        .mem_wr_i   (mem_q.wr_en),
        .mem_rd_i   (mem_q.rd),
        .load_use_o (lu_hit),
        .fwd_a_o    (fwd_a_nxt),
        .fwd_b_o    (fwd_b_nxt)
    );

    assign mem_req   = mem_q.valid & mem_q.is_mem;
    assign frozen    = ((state_q == RUN) & mem_req & ~mem_ready) |
                       ((state_q == MWAIT) & ~mem_ready);
    assign redir_acc = ex_redirect & ~frozen;
    // A redirect squashes the ID instruction, so its hazard no longer matters.
    assign load_use  = lu_hit & ~frozen & ~ex_redirect;

    assign pipe_freeze = frozen;
    assign pc_stall    = frozen | load_use;
    assign id_stall    = frozen | load_use;
    assign ex_bubble   = redir_acc | load_use;
    assign flush       = redir_acc;
    assign ex_fwd_a    = fwd_a_q;
    assign ex_fwd_b    = fwd_b_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

    assign enter_vld = id_valid & ~ex_bubble;

    always_comb begin
        id_slot = '0;
        if (enter_vld) begin
            id_slot.valid   = 1'b1;
            id_slot.rd      = id_rd;
            id_slot.wr_en   = writes_rd(id_op);
            id_slot.is_load = is_load(id_op);
            id_slot.is_mem  = is_mem(id_op);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (load_use && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        if (redir_acc && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN:     if (mem_req && !mem_ready) state_q <= MWAIT;
                MWAIT:   if (mem_ready) state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!frozen) begin
                ex_q    <= id_slot;
                mem_q   <= ex_q;
                wb_q    <= mem_q;
                fwd_a_q <= enter_vld ? fwd_a_nxt : FWD_RF;
                fwd_b_q <= enter_vld ? fwd_b_nxt : FWD_RF;
            end
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // WB occupancy is tracked for completeness; the write-through regfile
    // means nothing downstream needs it.
    logic unused_wb;
    assign unused_wb = ^{wb_q, mem_q.is_load};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed stimulus checked against an instruction-level
// model of the pipeline sequencing rules.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 8;
    localparam logic [3:0] ALUR = 4'b1100, ALUI = 4'b0100, CMPR = 4'b1101, CMPI = 4'b0101;
    localparam logic [3:0] LW = 4'b0111, SW = 4'b0011, BCOND = 4'b0010, JAL = 4'b0110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid = 1'b0;
    logic [3:0] id_op = '0, id_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic ex_redirect = 1'b0;
    logic mem_ready = 1'b1;
    logic pc_stall, id_stall, ex_bubble, flush, pipe_freeze, mem_req;
    logic [1:0] ex_fwd_a, ex_fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_chk = 0;
    int n_pass = 0;

    // Model: instructions currently in EX (index 0) and MEM (index 1).
    logic       m_v[2];
    logic [3:0] m_op[2];
    logic [3:0] m_rd[2];
    logic [1:0] m_fa, m_fb;
    logic [CW-1:0] m_sc, m_fc;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REGNO_SEL(4), .OP_FN_SIZ(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_redirect(ex_redirect), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .id_stall(id_stall), .ex_bubble(ex_bubble),
        .flush(flush), .pipe_freeze(pipe_freeze), .mem_req(mem_req),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit f_wr(input logic [3:0] op);
        return op inside {ALUR, ALUI, CMPR, CMPI, LW, JAL};
    endfunction
    function automatic bit f_r1(input logic [3:0] op);
        return op inside {ALUR, ALUI, CMPR, CMPI, LW, SW, BCOND, JAL};
    endfunction
    function automatic bit f_r2(input logic [3:0] op);
        return op inside {ALUR, CMPR, SW, BCOND};
    endfunction

    function automatic logic [1:0] m_src(input bit used, input logic [3:0] r);
        if (!used) return 2'b00;
        if (m_v[0] && f_wr(m_op[0]) && m_rd[0] == r) return 2'b01;
        if (m_v[1] && f_wr(m_op[1]) && m_rd[1] == r) return 2'b10;
        return 2'b00;
    endfunction

    task automatic m_clear();
        m_v[0] = 0; m_v[1] = 0; m_op[0] = 0; m_op[1] = 0; m_rd[0] = 0; m_rd[1] = 0;
        m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic step(input logic v, input logic [3:0] op, input logic [3:0] rd,
                        input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic rdr, input logic mrdy);
        bit mreq, frz, haz, redir, lu, bub;
        id_valid = v; id_op = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        ex_redirect = rdr; mem_ready = mrdy;
        mreq  = m_v[1] && (m_op[1] == LW || m_op[1] == SW);
        frz   = mreq && !mrdy;
        haz   = v && m_v[0] && m_op[0] == LW &&
                ((f_r1(op) && m_rd[0] == rs1) || (f_r2(op) && m_rd[0] == rs2));
        redir = rdr && !frz;
        lu    = haz && !frz && !rdr;
        bub   = redir || lu;
        #4;
        chk("ctl", {22'd0, pc_stall, id_stall, ex_bubble, flush, pipe_freeze, mem_req, ex_fwd_a, ex_fwd_b},
            {22'd0, frz | lu, frz | lu, bub, redir, frz, mreq, m_fa, m_fb});
        chk("cnt", {16'd0, stall_cnt, flush_cnt}, {16'd0, m_sc, m_fc});
        @(posedge clk);
        if (!frz) begin
            if (v && !bub) begin
                m_fa = m_src(f_r1(op), rs1);
                m_fb = m_src(f_r2(op), rs2);
            end else begin
                m_fa = 0; m_fb = 0;
            end
            m_v[1] = m_v[0]; m_op[1] = m_op[0]; m_rd[1] = m_rd[0];
            m_v[0] = v && !bub; m_op[0] = op; m_rd[0] = rd;
        end
        if (lu && m_sc != {CW{1'b1}}) m_sc = m_sc + 1'b1;
        if (redir && m_fc != {CW{1'b1}}) m_fc = m_fc + 1'b1;
        #1;
    endtask

    task automatic do_reset();
        id_valid = 0; ex_redirect = 0;
        rst_n = 0;
        @(posedge clk);
        m_clear();
        #1;
        rst_n = 1;
    endtask

    task automatic idle(input logic mrdy);
        step(0, 4'd0, 4'd0, 4'd0, 4'd0, 0, mrdy);
    endtask

    logic [3:0] op_tab[10];

    initial begin
        op_tab = '{ALUR, ALUI, CMPR, CMPI, LW, SW, BCOND, JAL, 4'b0000, 4'b1111};
        m_clear();
        @(posedge clk);
        do_reset();
        #4;
        chk("rst_out", {26'd0, pc_stall, id_stall, ex_bubble, flush, pipe_freeze, mem_req},
            32'd0);
        chk("rst_reg", {12'd0, ex_fwd_a, ex_fwd_b, stall_cnt, flush_cnt}, 32'd0);
        @(posedge clk); #1;

        // Load-use: LW r3, ALUR r4=r3+r5 stalls once then forwards from MEM/WB.
        step(1, LW, 4'd3, 4'd0, 4'd0, 0, 1);
        step(1, ALUR, 4'd4, 4'd3, 4'd5, 0, 1);
        chk("lu_cnt", {24'd0, stall_cnt}, 32'd1);
        step(1, ALUR, 4'd4, 4'd3, 4'd5, 0, 1);
        chk("lu_fwd", {30'd0, ex_fwd_a}, 32'd2);

        // Back-to-back ALU dependency: forward both operands from EX/MEM.
        step(1, ALUI, 4'd2, 4'd0, 4'd0, 0, 1);
        step(1, ALUR, 4'd6, 4'd2, 4'd2, 0, 1);
        chk("alu_fwd", {28'd0, ex_fwd_a, ex_fwd_b}, 32'h5);
        chk("alu_nostall", {24'd0, stall_cnt}, 32'd1);

        // SW reads rs2 -> stall; BCOND's rd field is not a read -> no stall.
        step(1, LW, 4'd7, 4'd0, 4'd0, 0, 1);
        step(1, SW, 4'd7, 4'd1, 4'd7, 0, 1);
        chk("sw_stall", {24'd0, stall_cnt}, 32'd2);
        step(1, SW, 4'd7, 4'd1, 4'd7, 0, 1);
        step(1, LW, 4'd7, 4'd0, 4'd0, 0, 1);
        step(1, BCOND, 4'd7, 4'd1, 4'd2, 0, 1);
        chk("bc_nostall", {24'd0, stall_cnt}, 32'd2);

        // Memory wait: LW reaches MEM, mem_ready low for 3 cycles.
        step(1, LW, 4'd9, 4'd0, 4'd0, 0, 1);
        idle(1);
        repeat (3) step(1, ALUR, 4'd1, 4'd9, 4'd9, 1, 0);
        chk("frz_noflush", {24'd0, flush_cnt}, 32'd0);
        step(1, ALUR, 4'd1, 4'd9, 4'd9, 0, 1);
        idle(1);

        // Redirect beats load-use.
        step(1, LW, 4'd3, 4'd0, 4'd0, 0, 1);
        step(1, ALUR, 4'd4, 4'd3, 4'd5, 1, 1);
        chk("rd_flush", {24'd0, flush_cnt}, 32'd1);
        chk("rd_nostall", {24'd0, stall_cnt}, 32'd2);

        // Reset in the middle of a memory wait.
        step(1, SW, 4'd0, 4'd1, 4'd2, 0, 1);
        idle(1);
        idle(0);
        mem_ready = 0;
        do_reset();
        idle(1);
        chk("mw_rst", {28'd0, pipe_freeze, mem_req, stall_cnt == 0, flush_cnt == 0}, 32'h3);

        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) != 0, op_tab[$urandom_range(0, 9)],
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
        end

        // Drive the stall counter into saturation.
        do_reset();
        for (int i = 0; i < 600; i++) step(1, LW, 4'd1, 4'd1, 4'd0, 0, 1);
        chk("sat", {24'd0, stall_cnt}, {24'd0, {CW{1'b1}}});
        do_reset();
        #4;
        chk("sat_rst", {12'd0, ex_fwd_a, ex_fwd_b, stall_cnt, flush_cnt}, 32'd0);
        chk("sat_rst_out", {26'd0, pc_stall, id_stall, ex_bubble, flush, pipe_freeze, mem_req},
            32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
